// File: rtl/types_pkg.sv
// Shared types for the strategy switcher: strategy codes, switch FSM states
// and a request-validity helper.
package types_pkg;

    typedef enum logic [7:0] {
        PASS    = 8'd0,
        INVERT  = 8'd1,
        DELAY   = 8'd2,
        STRETCH = 8'd3,
        EDGE    = 8'd4
    } strategy_e;

    localparam int STRAT_COUNT = 5;

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } switch_state_e;

    function automatic logic is_valid_strategy(input logic [7:0] code);
        return code < 8'(STRAT_COUNT);
    endfunction

endpackage

// File: rtl/strategy_channel.sv
// One channel's processing: delay line, previous sample and stretch counter.
// next_out is combinational; the top registers it into out_data.
module strategy_channel
    import types_pkg::*;
#(
    parameter int PAR_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_bit,
    input  strategy_e        mode,
    input  logic [PAR_W-1:0] par_q,
    input  logic             clear,
    output logic             next_out
);
    localparam int DEPTH = 2 ** PAR_W;

    logic [DEPTH-2:0] dline;
    logic [DEPTH-1:0] taps;
    logic [PAR_W-1:0] cnt;
    logic [PAR_W-1:0] cnt_next;
    logic [PAR_W-1:0] stretch_len;
    logic             prev;
    logic             rising;

    // taps[k] is the input k cycles ago; the first line stage doubles as the previous sample
    assign taps        = {dline, in_bit};
    assign prev        = dline[0];
    assign rising      = in_bit & ~prev;
    assign stretch_len = (par_q == '0) ? PAR_W'(1) : par_q;

    always_comb begin
        cnt_next = cnt;
        if (rising) begin
            cnt_next = stretch_len;
        end else if (cnt != '0) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dline <= '0;
            cnt   <= '0;
        end else if (clear) begin
            dline <= '0;
            cnt   <= '0;
        end else begin
            dline <= taps[DEPTH-2:0];
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_out = in_bit;
        case (mode)
            PASS:    next_out = in_bit;
            INVERT:  next_out = ~in_bit;
            DELAY:   next_out = taps[par_q];
            STRETCH: next_out = (cnt_next != '0);
            EDGE:    next_out = rising;
            default: next_out = in_bit;
        endcase
    end

endmodule

// File: rtl/strategy_switcher.sv
// N-channel strategy switcher: per-channel processing with a valid/ready
// strategy request and a GUARD-cycle blanking interval on every accepted switch.
module strategy_switcher
    import types_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PAR_W = 3,
    parameter int GUARD = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CH-1:0]   in_data,
    input  logic [7:0]        sel,
    input  logic [PAR_W-1:0]  par,
    input  logic              sel_valid,
    output logic              sel_ready,
    output logic [N_CH-1:0]   out_data,
    output logic [7:0]        active_sel,
    output logic              switching,
    output logic              sel_error,
    output switch_state_e     fsm_state
);
    localparam int CNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;

    logic [CNT_W-1:0] blank_cnt;
    logic [7:0]       pend_sel;
    logic [PAR_W-1:0] pend_par;
    logic [PAR_W-1:0] par_q;
    logic [N_CH-1:0]  next_bits;
    logic             blanking;
    logic             accept;
    strategy_e        mode;

    // A request transfers when sel_valid && sel_ready; invalid codes are refused with sel_error.
    assign blanking  = (fsm_state == BLANK);
    assign sel_ready = ~blanking;
    assign switching = blanking;
    assign accept    = sel_valid && sel_ready && is_valid_strategy(sel);
    assign mode      = strategy_e'(active_sel);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        strategy_channel #(.PAR_W(PAR_W)) u_ch (
            .clock    (clock),
            .reset    (reset),
            .in_bit   (in_data[i]),
            .mode     (mode),
            .par_q    (par_q),
            .clear    (blanking),
            .next_out (next_bits[i])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_state  <= RUN;
            active_sel <= 8'd0;
            par_q      <= '0;
            pend_sel   <= 8'd0;
            pend_par   <= '0;
            blank_cnt  <= '0;
            sel_error  <= 1'b0;
        end else begin
            sel_error <= 1'b0;
            case (fsm_state)
                RUN: begin
                    if (sel_valid) begin
                        if (is_valid_strategy(sel)) begin
                            pend_sel  <= sel;
                            pend_par  <= par;
                            blank_cnt <= CNT_W'(GUARD - 1);
                            fsm_state <= BLANK;
                        end else begin
                            sel_error <= 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (blank_cnt == '0) begin
                        active_sel <= pend_sel;
                        par_q      <= pend_par;
                        fsm_state  <= RUN;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                default: fsm_state <= RUN;
            endcase
        end
    end

    // Outputs go dark from the accepting edge through the last blanking cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
        end else if (accept || blanking) begin
            out_data <= '0;
        end else begin
            out_data <= next_bits;
        end
    end

endmodule

// File: tb/tb_strategy_switcher.sv
// Directed self-checking bench for strategy_switcher with an expected-output queue.
module tb_strategy_switcher;
    import types_pkg::*;

    localparam int N_CH  = 4;
    localparam int PAR_W = 3;
    localparam int GUARD = 4;

    logic              clock;
    logic              reset;
    logic [N_CH-1:0]   in_data;
    logic [7:0]        sel;
    logic [PAR_W-1:0]  par;
    logic              sel_valid;
    logic              sel_ready;
    logic [N_CH-1:0]   out_data;
    logic [7:0]        active_sel;
    logic              switching;
    logic              sel_error;
    switch_state_e     fsm_state;

    logic [N_CH-1:0]   exp_q[$];
    int                pass_cnt = 0;
    int                total_cnt = 0;

    strategy_switcher #(.N_CH(N_CH), .PAR_W(PAR_W), .GUARD(GUARD)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .sel        (sel),
        .par        (par),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .out_data   (out_data),
        .active_sel (active_sel),
        .switching  (switching),
        .sel_error  (sel_error),
        .fsm_state  (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // e is the out_data expected after the edge that samples d
    task automatic cyc(input logic [N_CH-1:0] d, input logic [N_CH-1:0] e);
        in_data = d;
        exp_q.push_back(e);
        step();
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out"}, 32'(out_data), 32'd0);
        chk({tag, "_active"}, 32'(active_sel), 32'd0);
        chk({tag, "_ready"}, 32'(sel_ready), 32'd1);
        chk({tag, "_switching"}, 32'(switching), 32'd0);
        chk({tag, "_error"}, 32'(sel_error), 32'd0);
        chk({tag, "_state"}, 32'(fsm_state), 32'(RUN));
    endtask

    // Issues a request and checks the whole blanking window up to the first RUN cycle.
    task automatic do_switch(input logic [7:0] code, input logic [PAR_W-1:0] p);
        sel       = code;
        par       = p;
        sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        par       = PAR_W'($urandom_range(0, 7));
        for (int i = 0; i < GUARD; i++) begin
            chk("blank_switching", 32'(switching), 32'd1);
            chk("blank_out", 32'(out_data), 32'd0);
            chk("blank_ready", 32'(sel_ready), 32'd0);
            in_data = N_CH'($urandom_range(0, 15));
            step();
        end
        chk("run_switching", 32'(switching), 32'd0);
        chk("run_out", 32'(out_data), 32'd0);
        chk("run_active", 32'(active_sel), 32'(code));
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = '0;
        sel       = 8'd0;
        par       = '0;
        sel_valid = 1'b0;
        step();
        step();
        check_reset_values("reset");
        reset = 1'b1;

        // PASS
        cyc(4'b1010, 4'b1010);
        cyc(4'b0101, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            logic [N_CH-1:0] d;
            d = N_CH'($urandom_range(0, 15));
            cyc(d, d);
        end
        chk("pass_active", 32'(active_sel), 32'd0);
        chk("pass_ready", 32'(sel_ready), 32'd1);

        // INVERT
        do_switch(8'd1, 3'd0);
        cyc(4'b0011, 4'b1100);
        for (int i = 0; i < 3; i++) begin
            logic [N_CH-1:0] d;
            d = N_CH'($urandom_range(0, 15));
            cyc(d, ~d);
        end

        // DELAY: pulse at C must appear at C+p+1
        for (int t = 0; t < 3; t++) begin
            logic [PAR_W-1:0] p;
            p = (t == 0) ? 3'd3 : (t == 1) ? 3'd7 : 3'd0;
            do_switch(8'd2, p);
            for (int k = 0; k <= int'(p) + 3; k++) begin
                cyc((k == 0) ? 4'b0001 : 4'b0000, (k == int'(p)) ? 4'b0001 : 4'b0000);
            end
        end

        // STRETCH par=5 on ch2: single edge, then retrigger 3 cycles later
        do_switch(8'd3, 3'd5);
        for (int k = 0; k < 8; k++) begin
            cyc((k == 0) ? 4'b0100 : 4'b0000, (k <= 4) ? 4'b0100 : 4'b0000);
        end
        for (int k = 0; k < 11; k++) begin
            cyc((k == 0 || k == 3) ? 4'b0100 : 4'b0000, (k <= 7) ? 4'b0100 : 4'b0000);
        end

        // EDGE on held-high ch1, then an invalid request
        do_switch(8'd4, 3'd0);
        cyc(4'b0010, 4'b0010);
        for (int k = 0; k < 3; k++) cyc(4'b0010, 4'b0000);
        sel       = 8'd9;
        sel_valid = 1'b1;
        in_data   = 4'b0010;
        step();
        sel_valid = 1'b0;
        chk("inv_error", 32'(sel_error), 32'd1);
        chk("inv_switching", 32'(switching), 32'd0);
        chk("inv_ready", 32'(sel_ready), 32'd1);
        chk("inv_active", 32'(active_sel), 32'd4);
        chk("inv_out", 32'(out_data), 32'd0);
        step();
        chk("inv_error_clear", 32'(sel_error), 32'd0);
        cyc(4'b0000, 4'b0000);
        cyc(4'b0010, 4'b0010);

        // Held sel_valid re-arms right after blanking ends
        sel       = 8'd4;
        par       = 3'd0;
        sel_valid = 1'b1;
        step();
        for (int i = 1; i < GUARD; i++) step();
        chk("rearm_last_blank", 32'(switching), 32'd1);
        step();
        chk("rearm_run", 32'(switching), 32'd0);
        chk("rearm_run_ready", 32'(sel_ready), 32'd1);
        step();
        sel_valid = 1'b0;
        chk("rearm_again", 32'(switching), 32'd1);
        for (int i = 0; i < GUARD; i++) step();
        chk("rearm_done", 32'(switching), 32'd0);

        // Reset during BLANK cycle 2 aborts the switch
        sel       = 8'd1;
        sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        step();
        chk("abort_in_blank", 32'(switching), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_values("abort_async");
        step();
        check_reset_values("abort_held");
        reset = 1'b1;
        step();
        chk("abort_active", 32'(active_sel), 32'd0);
        chk("abort_state", 32'(fsm_state), 32'(RUN));
        cyc(4'b1010, 4'b1010);
        cyc(4'b0110, 4'b0110);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
